pipe_stage_latch: RTL

PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

---
 rtl/pipe_stage_latch.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_stage_latch.sv
// Pipeline stage latch carrying NFIELDS packed fields with per-field write enable and flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_latch #(
    parameter int WIDTH   = 32,
    parameter int NFIELDS = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NFIELDS*WIDTH-1:0]   in_data,
    input  logic [NFIELDS-1:0]         field_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NFIELDS*WIDTH-1:0]   out_data
);

    localparam int DW = NFIELDS * WIDTH;

    // Disabled fields fall back to the most recently accepted bundle.
    function automatic logic [DW-1:0] merge_fields(input logic [DW-1:0]      new_d,
                                                   input logic [DW-1:0]      old_d,
                                                   input logic [NFIELDS-1:0] en);
        logic [DW-1:0] r;
        r = old_d;
        for (int k = 0; k < NFIELDS; k++) begin
            if (en[k]) r[k*WIDTH +: WIDTH] = new_d[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    logic          accept;
    logic [DW-1:0] merged;
    logic [DW-1:0] last_q;
    logic [DW-1:0] data_p0;
    logic          vld_p0;

    assign accept = in_valid && in_ready;
    assign merged = merge_fields(in_data, last_q, field_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (flush) begin
            last_q <= '0;
        end else if (accept) begin
            last_q <= merged;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic [DW-1:0] data_p1;
    logic          vld_p1;

    assign in_ready = !vld_p1;

    // ---- main register (p0) and skid register (p1) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (vld_p1) begin
            // Skid full means in_ready is low; only draining can happen.
            if (out_ready) begin
                data_p0 <= data_p1;
                vld_p1  <= 1'b0;
            end
        end else if (vld_p0 && !out_ready) begin
            if (accept) begin
                data_p1 <= merged;
                vld_p1  <= 1'b1;
            end
        end else if (accept) begin
            data_p0 <= merged;
            vld_p0  <= 1'b1;
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end
`else
    assign in_ready = out_ready || !vld_p0;

    // ---- single output register (p0) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (flush) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= merged;
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end
`endif

    assign out_valid = vld_p0;
    assign out_data  = data_p0;

endmodule
